// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - clear-then-draw sequencer with plot mux, clipping and pixel counters
module draw_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int CNT_W    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    output logic             fs_start,
    input  logic             fs_done,
    input  logic [7:0]       fs_x,
    input  logic [6:0]       fs_y,
    input  logic [2:0]       fs_colour,
    input  logic             fs_plot,
    output logic             rt_start,
    input  logic             rt_done,
    input  logic [7:0]       rt_x,
    input  logic [6:0]       rt_y,
    input  logic [2:0]       rt_colour,
    input  logic             rt_plot,
    output logic [7:0]       vga_x,
    output logic [6:0]       vga_y,
    output logic [2:0]       vga_colour,
    output logic             vga_plot,
    output logic [CNT_W-1:0] plot_count,
    output logic [CNT_W-1:0] clip_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    logic       sel_plot;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_colour;
    logic       in_range;

    // Route the engine owned by the current state; other strobes are dropped
    always_comb begin
        sel_plot   = 1'b0;
        sel_x      = 8'd0;
        sel_y      = 7'd0;
        sel_colour = 3'd0;
        case (state)
            FILL: begin
                sel_plot   = fs_plot;
                sel_x      = fs_x;
                sel_y      = fs_y;
                sel_colour = fs_colour;
            end
            DRAW: begin
                sel_plot   = rt_plot;
                sel_x      = rt_x;
                sel_y      = rt_y;
                sel_colour = rt_colour;
            end
            default: begin
                sel_plot = 1'b0;
            end
        endcase
        // Unsigned compare over the full input width, so 255/127 clip
        in_range = (32'(sel_x) < 32'(SCREEN_W)) && (32'(sel_y) < 32'(SCREEN_H));
    end

    // Sequencer FSM with registered engine starts, output pipeline and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            fs_start   <= 1'b0;
            rt_start   <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            plot_count <= '0;
            clip_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FILL;
                        fs_start   <= 1'b1;
                        plot_count <= '0;
                        clip_count <= '0;
                    end
                end
                FILL: begin
                    if (fs_done) begin
                        state    <= DRAW;
                        fs_start <= 1'b0;
                        rt_start <= 1'b1;
                    end
                end
                DRAW: begin
                    if (rt_done) begin
                        state    <= DONE;
                        rt_start <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A plot in the same cycle as an engine's done is still taken
            if (sel_plot) begin
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_colour;
                vga_plot   <= in_range;
                if (in_range) begin
                    if (plot_count != CNT_MAX) plot_count <= plot_count + 1'b1;
                end else begin
                    if (clip_count != CNT_MAX) clip_count <= clip_count + 1'b1;
                end
            end else begin
                vga_plot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// tb/tb_draw_sequencer.sv - self-checking bench for draw_sequencer
module tb_draw_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic        fs_start;
    logic        fs_done = 1'b0;
    logic [7:0]  fs_x = 8'd0;
    logic [6:0]  fs_y = 7'd0;
    logic [2:0]  fs_colour = 3'd0;
    logic        fs_plot = 1'b0;
    logic        rt_start;
    logic        rt_done = 1'b0;
    logic [7:0]  rt_x = 8'd0;
    logic [6:0]  rt_y = 7'd0;
    logic [2:0]  rt_colour = 3'd0;
    logic        rt_plot = 1'b0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [14:0] plot_count;
    logic [14:0] clip_count;

    int checks = 0;
    int errors = 0;

    draw_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .fs_start(fs_start), .fs_done(fs_done), .fs_x(fs_x), .fs_y(fs_y),
        .fs_colour(fs_colour), .fs_plot(fs_plot),
        .rt_start(rt_start), .rt_done(rt_done), .rt_x(rt_x), .rt_y(rt_y),
        .rt_colour(rt_colour), .rt_plot(rt_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .plot_count(plot_count), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       chk_xy;
    } exp_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       exp_plot;
    } vec_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, want);
        end
    endtask

    task automatic push_exp(input logic p, input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c, input logic chk_xy);
        exp_t e;
        e.plot = p; e.x = x; e.y = y; e.c = c; e.chk_xy = chk_xy;
        exp_q.push_back(e);
    endtask

    // Advance one clock, then compare any pending expected pixel
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("vga_plot", 32'(vga_plot), 32'(e.plot));
            if (e.chk_xy) begin
                chk("vga_x", 32'(vga_x), 32'(e.x));
                chk("vga_y", 32'(vga_y), 32'(e.y));
                chk("vga_colour", 32'(vga_colour), 32'(e.c));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_fs_start"}, 32'(fs_start), 0);
        chk({tag, "_rt_start"}, 32'(rt_start), 0);
        chk({tag, "_vga_x"}, 32'(vga_x), 0);
        chk({tag, "_vga_y"}, 32'(vga_y), 0);
        chk({tag, "_vga_colour"}, 32'(vga_colour), 0);
        chk({tag, "_vga_plot"}, 32'(vga_plot), 0);
        chk({tag, "_plot_count"}, 32'(plot_count), 0);
        chk({tag, "_clip_count"}, 32'(clip_count), 0);
    endtask

    initial begin
        vec_t vecs[8];
        int   n_in;
        int   n_clip;

        vecs[0] = '{8'd200, 7'd50,  3'd1, 1'b0};
        vecs[1] = '{8'd80,  7'd120, 3'd2, 1'b0};
        vecs[2] = '{8'd80,  7'd60,  3'd3, 1'b1};
        vecs[3] = '{8'd159, 7'd119, 3'd4, 1'b1};
        vecs[4] = '{8'd160, 7'd0,   3'd5, 1'b0};
        vecs[5] = '{8'd0,   7'd0,   3'd6, 1'b1};
        vecs[6] = '{8'd255, 7'd127, 3'd7, 1'b0};
        vecs[7] = '{8'd159, 7'd120, 3'd0, 1'b0};

        // Reset
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Start: enter FILL
        start = 1'b1;
        tick();
        chk("fill_fs_start", 32'(fs_start), 1);
        chk("fill_rt_start", 32'(rt_start), 0);

        // Triangle strobe during FILL is ignored
        rt_plot = 1'b1; rt_x = 8'd5; rt_y = 7'd5;
        push_exp(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick();
        rt_plot = 1'b0;
        chk("fill_rt_ignored_plot_count", 32'(plot_count), 0);

        // Full screen clear; fs_done rides on the final pixel
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                fs_plot   = 1'b1;
                fs_x      = 8'(x);
                fs_y      = 7'(y);
                fs_colour = 3'((x + y) & 7);
                fs_done   = (x == 159 && y == 119);
                push_exp(1'b1, 8'(x), 7'(y), 3'((x + y) & 7), 1'b1);
                tick();
            end
        end
        fs_plot = 1'b0; fs_done = 1'b0;
        chk("fill_plot_count", 32'(plot_count), 19200);
        chk("fill_clip_count", 32'(clip_count), 0);
        chk("draw_rt_start", 32'(rt_start), 1);
        chk("draw_fs_start", 32'(fs_start), 0);

        // Fillscreen strobe during DRAW is ignored; start drop is ignored too
        start = 1'b0;
        fs_plot = 1'b1; fs_x = 8'd3; fs_y = 7'd3;
        push_exp(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick();
        fs_plot = 1'b0;
        start = 1'b1;
        chk("draw_fs_ignored_plot_count", 32'(plot_count), 19200);
        chk("draw_still_running", 32'(rt_start), 1);

        // Clipping table
        n_in = 0; n_clip = 0;
        for (int i = 0; i < 8; i++) begin
            rt_plot   = 1'b1;
            rt_x      = vecs[i].x;
            rt_y      = vecs[i].y;
            rt_colour = vecs[i].c;
            push_exp(vecs[i].exp_plot, vecs[i].x, vecs[i].y, vecs[i].c, 1'b1);
            if (vecs[i].exp_plot) n_in++; else n_clip++;
            tick();
        end
        rt_plot = 1'b0;
        tick();
        chk("draw_vga_plot_idle", 32'(vga_plot), 0);
        chk("draw_vga_x_hold", 32'(vga_x), 159);
        chk("draw_clip_count", 32'(clip_count), 32'(n_clip));
        chk("draw_plot_count", 32'(plot_count), 32'(19200 + n_in));

        // Plot on the same cycle as rt_done is forwarded
        rt_plot = 1'b1; rt_x = 8'd10; rt_y = 7'd10; rt_colour = 3'd5; rt_done = 1'b1;
        push_exp(1'b1, 8'd10, 7'd10, 3'd5, 1'b1);
        tick();
        rt_plot = 1'b0; rt_done = 1'b0;
        chk("done_high", 32'(done), 1);
        chk("done_rt_start", 32'(rt_start), 0);
        chk("done_plot_count", 32'(plot_count), 32'(19200 + n_in + 1));

        // Plots in DONE ignored; done holds while start stays high
        rt_plot = 1'b1; fs_plot = 1'b1;
        push_exp(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        tick();
        tick();
        rt_plot = 1'b0; fs_plot = 1'b0;
        chk("done_hold", 32'(done), 1);
        chk("done_count_hold", 32'(plot_count), 32'(19200 + n_in + 1));

        start = 1'b0;
        tick();
        chk("idle_done_low", 32'(done), 0);
        chk("idle_count_hold", 32'(plot_count), 32'(19200 + n_in + 1));
        chk("idle_clip_hold", 32'(clip_count), 32'(n_clip));

        // Restart clears the counters
        start = 1'b1;
        tick();
        chk("restart_plot_count", 32'(plot_count), 0);
        chk("restart_clip_count", 32'(clip_count), 0);
        chk("restart_fs_start", 32'(fs_start), 1);

        // Reset midway through FILL aborts
        fs_plot = 1'b1; fs_x = 8'd7; fs_y = 7'd7; fs_colour = 3'd3;
        push_exp(1'b1, 8'd7, 7'd7, 3'd3, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; fs_plot = 1'b0;
        check_all_zero("midreset");

        // Rerun from FILL, then drive the plot counter into saturation
        tick();
        chk("rerun_fs_start", 32'(fs_start), 1);
        fs_plot = 1'b1; fs_x = 8'd1; fs_y = 7'd1; fs_colour = 3'd2;
        for (int i = 0; i < 32766; i++) begin
            push_exp(1'b1, 8'd1, 7'd1, 3'd2, 1'b0);
            tick();
        end
        chk("sat_pre", 32'(plot_count), 32766);
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b1, 8'd1, 7'd1, 3'd2, 1'b1);
            tick();
            chk("sat_count", 32'(plot_count), 32767);
        end
        fs_plot = 1'b0;
        chk("sat_clip", 32'(clip_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
